snax_csr_rmw_bridge: RTL
========================

Name: snax_csr_rmw_bridge

Overview:
- Upstream stage of the streamer/GEMM CSR port.
- Accepts offloaded RISC-V CSR instructions from the Snitch accelerator interface and decodes CSRRW/S/C and their immediate forms.
- Runs the required read / modify / write sequence on the simplified CSR request/response port of the streamer.
- Returns the old CSR value to the core on the accelerator response channel. One instruction is in flight at a time.

Parameters:
- CsrBase, 12'h3C0, first CSR address owned by the accelerator.
- NumCsr, 32, number of CSRs owned; the valid window is [CsrBase, CsrBase+NumCsr).
- IdWidth, 5, width of the accelerator request/response id.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- snax_qvalid_i  in  1  accelerator request valid
- snax_qready_o  out  1  accelerator request ready
- snax_req_op_i  in  32  offloaded instruction word
- snax_req_arga_i  in  32  rs1 value
- snax_req_id_i  in  IdWidth  request id (rd tag)
- snax_pvalid_o  out  1  response valid
- snax_pready_i  in  1  response ready
- snax_resp_data_o  out  32  old CSR value
- snax_resp_id_o  out  IdWidth  echoed id
- snax_resp_error_o  out  1  address outside the window
- io_csr_req_bits_data_o  out  32  write data
- io_csr_req_bits_addr_o  out  32  CSR index (csr - CsrBase), zero-extended
- io_csr_req_bits_write_o  out  1  1 = write, 0 = read
- io_csr_req_valid_o  out  1  CSR request valid
- io_csr_req_ready_i  in  1  CSR request ready
- io_csr_rsp_valid_i  in  1  read data valid
- io_csr_rsp_ready_o  out  1  read data ready
- io_csr_rsp_bits_data_i  in  32  read data
- busy_o  out  1  instruction in flight (feeds barrier)

Behaviour:
- Reset: every output is 0 except snax_qready_o = 1 (IDLE). All latches clear. An asserted reset mid-sequence aborts it immediately; no response is returned.
- Decode:
  - csr = op[31:20]; f3 = op[14:12]; rd = op[11:7]; rs1 = op[19:15].
  - Operand = arga when f3[2] = 0; otherwise zero-extended rs1 (zimm).
  - f3[1:0]: 01 = RW, 10 = RS, 11 = RC. Other encodings are handled as RS with operand 0 (read only).
- Read is needed when rd != 0 or the op is RS/RC.
- Write is needed when the op is RW, or when RS/RC has a nonzero source field (rs1/zimm field != 0; the field, not the value).
- Response is needed when rd != 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE: qready = 1. On qvalid & qready, latch op/arga/id and compute in_range.
    - Out of range: go to RESP with error = 1 and data = 0 if a response is needed, else stay in IDLE. No CSR traffic either way.
    - In range: go to RD_REQ if a read is needed, else WR_REQ; if neither is needed, handle as a read only.
  - RD_REQ: valid = 1, write = 0. On ready, go to RD_WAIT.
  - RD_WAIT: rsp_ready = 1. On rsp_valid, latch old.
    - New value: RW = operand; RS = old | operand; RC = old & ~operand.
    - Next: WR_REQ if a write is needed; else RESP if a response is needed; else IDLE.
  - WR_REQ: valid = 1, write = 1, data = new value (RW without a read writes the operand). On ready: RESP if a response is needed, else IDLE.
  - RESP: pvalid = 1 with data = old, latched id and error. On pready, go to IDLE.
- Request-channel rules:
  - addr, write and data are stable while valid is high and ready is low; valid is never dropped before the handshake.
  - Valid and ready may both rise in the same cycle.
- rsp_ready is 1 only in RD_WAIT. A rsp_valid pulse in any other state is ignored.
- busy_o = (state != IDLE). snax_qready_o = (state == IDLE). Back-to-back requests incur a minimum 1 idle cycle.
- Minimum latency from accept to pvalid for an in-range RS with rd != 0 and zero-wait CSR: 3 cycles (accept, RD_REQ, RD_WAIT, RESP asserted in cycle 3).
- Address arithmetic: index = csr - CsrBase on 12 bits, zero-extended to 32. in_range = (csr >= CsrBase) && (csr - CsrBase < NumCsr).

Test Plan:
- csrrw x5, 0x3C2 with arga = 0xDEADBEEF, CSR[2] = 0x11 -> read addr 2, then write addr 2 data 0xDEADBEEF; resp data 0x11, id 5, error 0.
- csrrs x0, 0x3C4 with rs1 field nonzero, arga = 0x0F, CSR[4] = 0xF0 -> read, then write 0xFF; no pvalid.
- csrrci x7, 0x3C1, zimm = 0x3, CSR[1] = 0x7 -> write 0x4; resp 0x7.
- csrr x3, 0x3E5 (index 37, out of range) -> no CSR valid ever; resp error 1, data 0, id 3.
- io_csr_req_ready_i held low 5 cycles, then snax_pready_i low 3 cycles -> req fields stable, qready stays 0, busy_o 1 throughout, single response.
- Reset asserted in RD_WAIT -> all outputs at reset values next edge; a new request after reset completes normally.

Source files
------------

// File: rtl/snax_csr_rmw_bridge.sv
// Snitch accelerator CSR offload -> streamer CSR port bridge.
// Decodes CSRRW/S/C(I), runs the read/modify/write sequence and returns the old value.
module snax_csr_rmw_bridge #(
  parameter logic [11:0] CsrBase = 12'h3C0,
  parameter int unsigned NumCsr  = 32,
  parameter int unsigned IdWidth = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               snax_qvalid_i,
  output logic               snax_qready_o,
  input  logic [31:0]        snax_req_op_i,
  input  logic [31:0]        snax_req_arga_i,
  input  logic [IdWidth-1:0] snax_req_id_i,
  output logic               snax_pvalid_o,
  input  logic               snax_pready_i,
  output logic [31:0]        snax_resp_data_o,
  output logic [IdWidth-1:0] snax_resp_id_o,
  output logic               snax_resp_error_o,
  output logic [31:0]        io_csr_req_bits_data_o,
  output logic [31:0]        io_csr_req_bits_addr_o,
  output logic               io_csr_req_bits_write_o,
  output logic               io_csr_req_valid_o,
  input  logic               io_csr_req_ready_i,
  input  logic               io_csr_rsp_valid_i,
  output logic               io_csr_rsp_ready_o,
  input  logic [31:0]        io_csr_rsp_bits_data_i,
  output logic               busy_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;

  state_e r_state, w_state_nxt;

  logic [31:7]        r_op;
  logic [31:0]        r_arga;
  logic [31:0]        r_old;
  logic [IdWidth-1:0] r_id;
  logic               r_err;

  // Decode the live request while idle so the accept cycle can already pick the path.
  logic [31:7] w_op;
  logic [31:0] w_arga;
  assign w_op   = (r_state == IDLE) ? snax_req_op_i[31:7] : r_op;
  assign w_arga = (r_state == IDLE) ? snax_req_arga_i     : r_arga;

  logic w_unused;
  assign w_unused = ^snax_req_op_i[6:0];

  logic [11:0] w_csr, w_idx;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1;
  logic        w_in_range, w_is_rw, w_is_rc, w_is_ro;
  logic        w_need_rd, w_need_wr, w_need_resp, w_acc;
  logic [31:0] w_operand, w_new;

  assign w_csr      = w_op[31:20];
  assign w_rs1      = w_op[19:15];
  assign w_f3       = w_op[14:12];
  assign w_rd       = w_op[11:7];
  assign w_idx      = w_csr - CsrBase;
  assign w_in_range = (w_csr >= CsrBase) && ({20'd0, w_idx} < NumCsr);

  // f3[1:0] == 00 is not a CSR op: treated as a set with a zero operand, i.e. a pure read.
  assign w_is_rw   = (w_f3[1:0] == 2'b01);
  assign w_is_rc   = (w_f3[1:0] == 2'b11);
  assign w_is_ro   = (w_f3[1:0] == 2'b00);
  assign w_operand = w_is_ro ? 32'd0 : (w_f3[2] ? {27'd0, w_rs1} : w_arga);

  assign w_need_rd   = (w_rd != 5'd0) || !w_is_rw;
  assign w_need_wr   = w_is_rw || (!w_is_ro && (w_rs1 != 5'd0));
  assign w_need_resp = (w_rd != 5'd0);

  assign w_new = w_is_rw ? w_operand :
                 w_is_rc ? (r_old & ~w_operand) : (r_old | w_operand);

  assign w_acc = snax_qvalid_i && (r_state == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc) begin
        if (!w_in_range)    w_state_nxt = w_need_resp ? RESP : IDLE;
        else if (w_need_rd) w_state_nxt = RD_REQ;
        else                w_state_nxt = WR_REQ;
      end
      RD_REQ:  if (io_csr_req_ready_i) w_state_nxt = RD_WAIT;
      RD_WAIT: if (io_csr_rsp_valid_i)
                 w_state_nxt = w_need_wr ? WR_REQ : (w_need_resp ? RESP : IDLE);
      WR_REQ:  if (io_csr_req_ready_i) w_state_nxt = w_need_resp ? RESP : IDLE;
      RESP:    if (snax_pready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snax_qready_o           = 1'b0;
    snax_pvalid_o           = 1'b0;
    snax_resp_data_o        = '0;
    snax_resp_id_o          = '0;
    snax_resp_error_o       = 1'b0;
    io_csr_req_valid_o      = 1'b0;
    io_csr_req_bits_write_o = 1'b0;
    io_csr_req_bits_addr_o  = '0;
    io_csr_req_bits_data_o  = '0;
    io_csr_rsp_ready_o      = 1'b0;
    case (r_state)
      IDLE:    snax_qready_o = 1'b1;
      RD_REQ: begin
        io_csr_req_valid_o     = 1'b1;
        io_csr_req_bits_addr_o = {20'd0, w_idx};
      end
      RD_WAIT: io_csr_rsp_ready_o = 1'b1;
      WR_REQ: begin
        io_csr_req_valid_o      = 1'b1;
        io_csr_req_bits_write_o = 1'b1;
        io_csr_req_bits_addr_o  = {20'd0, w_idx};
        io_csr_req_bits_data_o  = w_new;
      end
      RESP: begin
        snax_pvalid_o     = 1'b1;
        snax_resp_data_o  = r_old;
        snax_resp_id_o    = r_id;
        snax_resp_error_o = r_err;
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != IDLE);

  // Request fields are held in r_* for the whole sequence, keeping the CSR request stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op   <= '0;
      r_arga <= '0;
      r_id   <= '0;
      r_err  <= 1'b0;
      r_old  <= '0;
    end else if (w_acc) begin
      r_op   <= snax_req_op_i[31:7];
      r_arga <= snax_req_arga_i;
      r_id   <= snax_req_id_i;
      r_err  <= !w_in_range;
      r_old  <= '0;
    end else if ((r_state == RD_WAIT) && io_csr_rsp_valid_i) begin
      r_old  <= io_csr_rsp_bits_data_i;
    end
  end

endmodule
